// File: rtl/pool_layer_scheduler.sv
// Layer sequencer for the 2x2 max-pooling engine.
// Walks channel groups: load, start, count saves, check.
module pool_layer_scheduler #(
  parameter int unsigned NUM_GROUPS     = 4,
  parameter int unsigned POOL_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        load_req,
  input  logic        load_done,
  output logic [15:0] group_sel,
  output logic        pool_start,
  input  logic        pool_save_enable,
  input  logic        pool_done,
  output logic        busy,
  output logic        layer_done,
  output logic        err_count,
  output logic        err_timeout,
  output logic [15:0] save_total
);

  localparam int unsigned WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [31:0] EXP_SAVES =
    32'((POOL_WIDTH / 2) * (POOL_WIDTH / 2));

  localparam logic [15:0] LAST_GROUP =
    16'(NUM_GROUPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    CHECK,
    DONE
  } state_t;

  state_t          state;
  logic [WD_W-1:0] watchdog;

  // Handshake outputs decode the state register only
  assign load_req   = (state == LOAD);
  assign pool_start = (state == START);
  assign busy       = (state != IDLE);
  assign layer_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      group_sel   <= '0;
      err_count   <= 1'b0;
      err_timeout <= 1'b0;
      save_total  <= '0;
      watchdog    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            group_sel   <= '0;
            err_count   <= 1'b0;
            err_timeout <= 1'b0;
            save_total  <= '0;
          end
        end
        LOAD: begin
          if (load_done) state <= START;
        end
        START: begin
          save_total <= '0;
          watchdog   <= '0;
          state      <= RUN;
        end
        RUN: begin
          if (pool_save_enable &&
              save_total != 16'hFFFF)
            save_total <= save_total + 16'd1;
          watchdog <= watchdog + WD_W'(1);
          // A done on the last allowed cycle beats the hang
          if (pool_done) begin
            state <= CHECK;
          end else if (watchdog == WD_LAST) begin
            err_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        CHECK: begin
          if ({16'd0, save_total} != EXP_SAVES)
            err_count <= 1'b1;
          if (group_sel == LAST_GROUP) begin
            state <= DONE;
          end else begin
            group_sel <= group_sel + 16'd1;
            state     <= LOAD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_layer_scheduler.sv
// Directed bench for pool_layer_scheduler.
// Two groups, 4x4 map (4 saves/group), 8-cycle watchdog.
module tb_pool_layer_scheduler;

  localparam int NG = 2;
  localparam int PW = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_req;
  logic        load_done;
  logic [15:0] group_sel;
  logic        pool_start;
  logic        pool_save_enable;
  logic        pool_done;
  logic        busy;
  logic        layer_done;
  logic        err_count;
  logic        err_timeout;
  logic [15:0] save_total;

  int checks = 0;
  int passed = 0;

  pool_layer_scheduler #(
    .NUM_GROUPS    (NG),
    .POOL_WIDTH    (PW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .load_req        (load_req),
    .load_done       (load_done),
    .group_sel       (group_sel),
    .pool_start      (pool_start),
    .pool_save_enable(pool_save_enable),
    .pool_done       (pool_done),
    .busy            (busy),
    .layer_done      (layer_done),
    .err_count       (err_count),
    .err_timeout     (err_timeout),
    .save_total      (save_total)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Precondition: in LOAD. Ends in START.
  task automatic do_load(input logic [15:0] g);
    tick();
    tick();
    checks++;
    if (load_req !== 1'b1)
      $display("FAIL load_req_hold: got %b want 1", load_req);
    else passed++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    checks++;
    if (pool_start !== 1'b1)
      $display("FAIL pool_start_hi: got %b want 1", pool_start);
    else passed++;
    checks++;
    if (group_sel !== g)
      $display("FAIL group_sel: got %0d want %0d", group_sel, g);
    else passed++;
  endtask

  // Precondition: in START. Ends in CHECK (or DONE on timeout).
  task automatic run_saves(input int n, input bit coincide,
                           input int gap);
    tick();
    checks++;
    if (pool_start !== 1'b0)
      $display("FAIL pool_start_lo: got %b want 0", pool_start);
    else passed++;
    for (int i = 0; i < n; i++) begin
      pool_save_enable = 1'b1;
      pool_done = coincide && (i == n - 1);
      tick();
    end
    pool_save_enable = 1'b0;
    pool_done = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    if (!coincide) begin
      pool_done = 1'b1;
      tick();
      pool_done = 1'b0;
    end
    checks++;
    if (save_total !== 16'(n))
      $display("FAIL save_total_check: got %0d want %0d",
               save_total, n);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    load_done = 1'b0;
    pool_save_enable = 1'b0;
    pool_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({load_req, pool_start, busy, layer_done} !== 4'b0000)
      $display("FAIL rst_ctrl: got %b want 0000",
               {load_req, pool_start, busy, layer_done});
    else passed++;
    checks++;
    if ({err_count, err_timeout} !== 2'b00)
      $display("FAIL rst_err: got %b want 00",
               {err_count, err_timeout});
    else passed++;
    checks++;
    if (group_sel !== 16'd0 || save_total !== 16'd0)
      $display("FAIL rst_cnt: got g=%0d s=%0d want 0 0",
               group_sel, save_total);
    else passed++;
  endtask

  task automatic test_nominal();
    pulse_start();
    checks++;
    if (load_req !== 1'b1 || busy !== 1'b1)
      $display("FAIL nom_load: got lr=%b busy=%b want 1 1",
               load_req, busy);
    else passed++;
    do_load(16'd0);
    run_saves(4, 1'b0, 0);
    tick();
    checks++;
    if (load_req !== 1'b1 || group_sel !== 16'd1)
      $display("FAIL nom_next: got lr=%b g=%0d want 1 1",
               load_req, group_sel);
    else passed++;
    do_load(16'd1);
    run_saves(4, 1'b0, 0);
    tick();
    checks++;
    if (layer_done !== 1'b1)
      $display("FAIL nom_layer_done: got %b want 1", layer_done);
    else passed++;
    checks++;
    if ({err_count, err_timeout} !== 2'b00)
      $display("FAIL nom_err: got %b want 00",
               {err_count, err_timeout});
    else passed++;
    tick();
    checks++;
    if (layer_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL nom_idle: got ld=%b busy=%b want 0 0",
               layer_done, busy);
    else passed++;
    checks++;
    if (save_total !== 16'd4)
      $display("FAIL nom_save_hold: got %0d want 4", save_total);
    else passed++;
  endtask

  task automatic test_ignored();
    pool_save_enable = 1'b1;
    pool_done = 1'b1;
    load_done = 1'b1;
    tick();
    tick();
    pool_save_enable = 1'b0;
    pool_done = 1'b0;
    load_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || save_total !== 16'd4)
      $display("FAIL ign_idle: got busy=%b s=%0d want 0 4",
               busy, save_total);
    else passed++;
    pulse_start();
    pool_save_enable = 1'b1;
    pool_done = 1'b1;
    tick();
    pool_save_enable = 1'b0;
    pool_done = 1'b0;
    checks++;
    if (load_req !== 1'b1 || save_total !== 16'd0)
      $display("FAIL ign_load: got lr=%b s=%0d want 1 0",
               load_req, save_total);
    else passed++;
    do_load(16'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_req !== 1'b0 ||
        pool_start !== 1'b0)
      $display("FAIL ign_run_start: got b=%b lr=%b ps=%b want 1 0 0",
               busy, load_req, pool_start);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      pool_save_enable = 1'b1;
      tick();
    end
    pool_save_enable = 1'b0;
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    checks++;
    if (save_total !== 16'd4)
      $display("FAIL ign_save: got %0d want 4", save_total);
    else passed++;
    tick();
    do_load(16'd1);
    run_saves(4, 1'b0, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || load_req !== 1'b0)
      $display("FAIL ign_done_start: got b=%b lr=%b want 0 0",
               busy, load_req);
    else passed++;
  endtask

  task automatic test_mismatch();
    pulse_start();
    do_load(16'd0);
    run_saves(3, 1'b0, 0);
    tick();
    checks++;
    if (err_count !== 1'b1)
      $display("FAIL mis_err_set: got %b want 1", err_count);
    else passed++;
    do_load(16'd1);
    run_saves(4, 1'b0, 0);
    tick();
    checks++;
    if (layer_done !== 1'b1 || err_count !== 1'b1)
      $display("FAIL mis_done: got ld=%b ec=%b want 1 1",
               layer_done, err_count);
    else passed++;
    tick();
    tick();
    checks++;
    if (err_count !== 1'b1)
      $display("FAIL mis_sticky: got %b want 1", err_count);
    else passed++;
  endtask

  task automatic test_simultaneous();
    pulse_start();
    checks++;
    if (err_count !== 1'b0)
      $display("FAIL sim_clear: got %b want 0", err_count);
    else passed++;
    do_load(16'd0);
    run_saves(4, 1'b1, 0);
    tick();
    checks++;
    if (err_count !== 1'b0)
      $display("FAIL sim_coincide_err: got %b want 0", err_count);
    else passed++;
    do_load(16'd1);
    // 4 saves + 3 idle, done on the 8th RUN cycle
    run_saves(4, 1'b0, 3);
    checks++;
    if (err_timeout !== 1'b0 || layer_done !== 1'b0)
      $display("FAIL sim_wd_edge: got et=%b ld=%b want 0 0",
               err_timeout, layer_done);
    else passed++;
    tick();
    checks++;
    if (layer_done !== 1'b1 || err_timeout !== 1'b0 ||
        err_count !== 1'b0)
      $display("FAIL sim_done: got ld=%b et=%b ec=%b want 1 0 0",
               layer_done, err_timeout, err_count);
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int lr_seen;
    pulse_start();
    do_load(16'd0);
    for (int i = 0; i < TO; i++) tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1)
      $display("FAIL to_early: got et=%b b=%b want 0 1",
               err_timeout, busy);
    else passed++;
    tick();
    checks++;
    if (err_timeout !== 1'b1 || layer_done !== 1'b1)
      $display("FAIL to_flag: got et=%b ld=%b want 1 1",
               err_timeout, layer_done);
    else passed++;
    lr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (load_req === 1'b1) lr_seen++;
    end
    checks++;
    if (lr_seen != 0 || busy !== 1'b0 || err_timeout !== 1'b1)
      $display("FAIL to_after: got lr=%0d b=%b et=%b want 0 0 1",
               lr_seen, busy, err_timeout);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    checks++;
    if (err_timeout !== 1'b0)
      $display("FAIL rmr_clear: got %b want 0", err_timeout);
    else passed++;
    do_load(16'd0);
    run_saves(3, 1'b0, 0);
    tick();
    do_load(16'd1);
    tick();
    pool_save_enable = 1'b1;
    tick();
    pool_save_enable = 1'b0;
    checks++;
    if (err_count !== 1'b1 || save_total !== 16'd1)
      $display("FAIL rmr_pre: got ec=%b s=%0d want 1 1",
               err_count, save_total);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({load_req, pool_start, busy, layer_done,
         err_count, err_timeout} !== 6'b0)
      $display("FAIL rmr_flags: got %b want 000000",
               {load_req, pool_start, busy, layer_done,
                err_count, err_timeout});
    else passed++;
    checks++;
    if (group_sel !== 16'd0 || save_total !== 16'd0)
      $display("FAIL rmr_cnt: got g=%0d s=%0d want 0 0",
               group_sel, save_total);
    else passed++;
    pulse_start();
    do_load(16'd0);
    run_saves(4, 1'b0, 0);
    tick();
    do_load(16'd1);
    run_saves(4, 1'b0, 0);
    tick();
    checks++;
    if (layer_done !== 1'b1 || err_count !== 1'b0)
      $display("FAIL rmr_done: got ld=%b ec=%b want 1 0",
               layer_done, err_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ignored();
    test_mismatch();
    test_simultaneous();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
